imem_loader: RTL

// - Program-load front end for the miniRISC CPU: writes instruction memory, which the CPU fetch path reads.
// - Accepts a byte stream (valid/ready) and packs it into 32-bit little-endian instruction words.
// - Writes each word to consecutive imem addresses from 0 and holds the CPU in reset while loading.
// - Releases CPU reset after RST_HOLD cycles, so benches can boot programs such as the shift/compi tests without $readmemh.

---
 rtl/imem_loader.sv | 132 +++++++++++++
 1 files changed

// File: rtl/imem_loader.sv
// Program-load front end: packs a little-endian byte stream into 32-bit words, writes them to
// instruction memory from address 0, and holds the CPU in reset until the load is complete.
module imem_loader #(
    parameter int unsigned ADDR_W   = 10,
    parameter int unsigned DEPTH    = 1024,
    parameter int unsigned RST_HOLD = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    input  logic [7:0]        s_data,
    input  logic              s_last,
    output logic              s_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_rst,
    output logic              load_done,
    output logic [ADDR_W:0]   word_cnt,
    output logic              err_partial,
    output logic              overflow
);

    localparam int unsigned HoldW = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;

    typedef enum logic [1:0] {StLoad, StWrite, StHold, StRun} state_e;

    state_e            state_q, state_d;
    logic [1:0]        byte_idx_q, byte_idx_d;
    logic [31:0]       word_q, word_d;
    logic              last_q, last_d;
    logic [ADDR_W:0]   word_cnt_q, word_cnt_d;
    logic              err_partial_q, err_partial_d;
    logic              overflow_q, overflow_d;
    logic [HoldW-1:0]  hold_cnt_q, hold_cnt_d;

    logic              accept;
    logic [ADDR_W:0]   cnt_inc;
    logic              at_cap;

    assign accept  = s_valid && s_ready;
    assign cnt_inc = word_cnt_q + 1'b1;
    assign at_cap  = (cnt_inc == (ADDR_W + 1)'(DEPTH));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StLoad;
            byte_idx_q    <= '0;
            word_q        <= '0;
            last_q        <= 1'b0;
            word_cnt_q    <= '0;
            err_partial_q <= 1'b0;
            overflow_q    <= 1'b0;
            hold_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            byte_idx_q    <= byte_idx_d;
            word_q        <= word_d;
            last_q        <= last_d;
            word_cnt_q    <= word_cnt_d;
            err_partial_q <= err_partial_d;
            overflow_q    <= overflow_d;
            hold_cnt_q    <= hold_cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StLoad: begin
                if (accept && (byte_idx_q == 2'd3 || s_last)) begin
                    state_d = StWrite;
                end
            end
            StWrite: state_d = (last_q || at_cap) ? StHold : StLoad;
            StHold: begin
                if (hold_cnt_q == HoldW'(RST_HOLD - 1)) begin
                    state_d = StRun;
                end
            end
            StRun:   state_d = StRun;
            default: state_d = StLoad;
        endcase
    end

    always_comb begin
        byte_idx_d    = byte_idx_q;
        word_d        = word_q;
        last_d        = last_q;
        word_cnt_d    = word_cnt_q;
        err_partial_d = err_partial_q;
        overflow_d    = overflow_q;
        hold_cnt_d    = hold_cnt_q;
        unique case (state_q)
            StLoad: begin
                if (accept) begin
                    word_d[{byte_idx_q, 3'b000} +: 8] = s_data;
                    byte_idx_d = s_last ? 2'd0 : byte_idx_q + 2'd1;
                    last_d     = s_last;
                    if (s_last && byte_idx_q != 2'd3) begin
                        err_partial_d = 1'b1;
                    end
                end
            end
            StWrite: begin
                word_cnt_d = cnt_inc;
                // Clearing here makes a short final word come out zero-padded.
                word_d     = '0;
                last_d     = 1'b0;
                hold_cnt_d = '0;
                if (!last_q && at_cap) begin
                    overflow_d = 1'b1;
                end
            end
            StHold:  hold_cnt_d = hold_cnt_q + 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        s_ready     = (state_q == StLoad) && !rst;
        imem_we     = (state_q == StWrite);
        imem_addr   = imem_we ? word_cnt_q[ADDR_W-1:0] : '0;
        imem_wdata  = imem_we ? word_q : '0;
        cpu_rst     = (state_q != StRun);
        load_done   = (state_q == StRun);
        word_cnt    = word_cnt_q;
        err_partial = err_partial_q;
        overflow    = overflow_q;
    end

endmodule
